spi_master_gen: RTL

//  Runtime-configurable SPI master: all four CPOL/CPHA modes, DATA_W-bit words, MSB/LSB-first,
//  NUM_CS chip selects, and valid/ready TX streaming with underrun stall. Successor to the fixed

---
 rtl/spi_master_gen.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_gen.sv
// SPI master with runtime CPOL/CPHA, bit order, clock divider and chip select,
// fed by a valid/ready TX stream and emitting one RX pulse per received word.
module spi_master_gen #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8,
    parameter int LEN_W  = 8,
    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CSW-1:0]    cs_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic [LEN_W-1:0]  n_words_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              tx_ready_o,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [LEN_W-1:0]  rx_idx_o,
    output logic              spi_sck_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic [NUM_CS-1:0] spi_cs_n_o
);
    localparam int EW = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_LOAD,
        S_SHIFT,
        S_CS_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [EW-1:0]      r_edge;
    logic [LEN_W-1:0]   r_nwords;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [DATA_W-1:0]  r_tx;
    logic [DATA_W-1:0]  r_rx;
    logic [DATA_W-1:0]  r_rx_data;
    logic [LEN_W-1:0]   r_rx_idx;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_lsb;
    logic               r_sck;
    logic               r_mosi;
    logic               r_done;
    logic               r_rx_valid;
    logic [NUM_CS-1:0]  r_cs_n;

    logic               w_cnt_end;
    logic               w_reject;
    logic               w_abort;
    logic               w_hs;
    logic               w_edge;
    logic               w_last;
    logic               w_more;
    logic               w_sample;
    logic [DATA_W-1:0]  w_rx_shift;

    function automatic logic f_out_bit(input logic [DATA_W-1:0] word, input logic lsb);
        return lsb ? word[0] : word[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] word,
                                                  input logic lsb, input logic fill);
        return lsb ? {fill, word[DATA_W-1:1]} : {word[DATA_W-2:0], fill};
    endfunction

    assign w_cnt_end  = (r_cnt == r_div - DIV_W'(1));
    assign w_reject   = (n_words_i == '0) || (32'(cs_sel_i) >= 32'(NUM_CS));
    assign w_abort    = abort_i && (r_state != S_IDLE);
    assign w_hs       = (r_state == S_LOAD) && tx_valid_i && !abort_i;
    assign w_edge     = (r_state == S_SHIFT) && w_cnt_end && !abort_i;
    assign w_last     = (r_edge == EW'(2 * DATA_W - 1));
    assign w_more     = (r_word_cnt != r_nwords - LEN_W'(1));
    // Even edge index = leading edge; CPHA flips which edge samples.
    assign w_sample   = (~r_edge[0]) ^ r_cpha;
    assign w_rx_shift = f_shift(r_rx, r_lsb, spi_miso_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start_i && !w_reject) w_state_nxt = S_CS_SETUP;
            S_CS_SETUP: if (w_cnt_end) w_state_nxt = S_LOAD;
            S_LOAD:     if (tx_valid_i) w_state_nxt = S_SHIFT;
            S_SHIFT:    if (w_cnt_end && w_last) w_state_nxt = w_more ? S_LOAD : S_CS_HOLD;
            S_CS_HOLD:  if (w_cnt_end) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_div      <= DIV_W'(1);
            r_edge     <= '0;
            r_nwords   <= '0;
            r_word_cnt <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_idx   <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;

            case (r_state)
                S_CS_SETUP, S_SHIFT, S_CS_HOLD: r_cnt <= w_cnt_end ? '0 : r_cnt + DIV_W'(1);
                default:                        r_cnt <= '0;
            endcase

            if (r_state == S_IDLE) begin
                r_sck  <= cpol_i;
                r_mosi <= 1'b0;
                if (start_i) begin
                    if (w_reject) begin
                        r_done <= 1'b1;
                    end else begin
                        r_cpol     <= cpol_i;
                        r_cpha     <= cpha_i;
                        r_lsb      <= lsb_first_i;
                        r_div      <= (clk_div_i == '0) ? DIV_W'(1) : clk_div_i;
                        r_nwords   <= n_words_i;
                        r_word_cnt <= '0;
                        r_cs_n     <= ~(NUM_CS'(1) << cs_sel_i);
                    end
                end
            end else if (w_abort) begin
                r_sck  <= r_cpol;
                r_cs_n <= '1;
                r_done <= 1'b1;
            end else begin
                if (w_hs) begin
                    r_edge <= '0;
                    if (!r_cpha) begin
                        r_mosi <= f_out_bit(tx_data_i, r_lsb);
                        r_tx   <= f_shift(tx_data_i, r_lsb, 1'b0);
                    end else begin
                        r_tx   <= tx_data_i;
                    end
                end

                if (w_edge) begin
                    r_sck  <= ~r_sck;
                    r_edge <= r_edge + EW'(1);
                    if (w_sample) begin
                        r_rx <= w_rx_shift;
                    end else if (!w_last) begin
                        r_mosi <= f_out_bit(r_tx, r_lsb);
                        r_tx   <= f_shift(r_tx, r_lsb, 1'b0);
                    end
                    if (w_last) begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= w_sample ? w_rx_shift : r_rx;
                        r_rx_idx   <= r_word_cnt;
                        r_word_cnt <= r_word_cnt + LEN_W'(1);
                    end
                end

                if ((r_state == S_CS_HOLD) && w_cnt_end) begin
                    r_cs_n <= '1;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = (r_state != S_IDLE);
    assign tx_ready_o = (r_state == S_LOAD);
    assign done_o     = r_done;
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign rx_idx_o   = r_rx_idx;
    assign spi_sck_o  = r_sck;
    assign spi_mosi_o = r_mosi;
    assign spi_cs_n_o = r_cs_n;

endmodule
